// File: rtl/reverb_pkg.sv
// Shared constants and types for the reverb datapath arithmetic blocks.
package reverb_pkg;

    localparam int          DATA_W    = 24;
    localparam int          FRAC_BITS = 8;
    localparam logic [23:0] Q_MAX     = 24'h7FFFFF;
    localparam logic [23:0] Q_MIN     = 24'h800000;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step on unsigned magnitudes.
module div_step #(
    parameter int N = 24
) (
    input  logic [N-1:0] rem_in,
    input  logic         bit_in,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] rem_out,
    output logic         q_bit
);

    // One extra bit so the shifted remainder can exceed the divisor width.
    logic [N:0] trial;

    assign trial   = {rem_in, bit_in};
    assign q_bit   = (trial >= {1'b0, divisor});
    // The difference is always below the divisor, so the low N bits are exact.
    assign rem_out = q_bit ? (trial[N-1:0] - divisor) : trial[N-1:0];

endmodule

// File: rtl/fixed_point_divider.sv
// Sequential signed fixed-point divider R = (A << FRAC) / B, one quotient bit per clock,
// with saturation and ALU-compatible flags.
module fixed_point_divider
    import reverb_pkg::*;
#(
    parameter int N    = DATA_W,
    parameter int FRAC = FRAC_BITS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] R,
    output logic         Z,
    output logic         C,
    output logic         V,
    output logic         Neg,
    output logic         DZ
);

    localparam int              QW        = N + FRAC;
    localparam int              CW        = $clog2(QW + 1);
    localparam logic [N-1:0]    R_MAX     = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0]    R_MIN     = {1'b1, {(N-1){1'b0}}};
    localparam logic [QW-1:0]   Q_POS_LIM = {{FRAC{1'b0}}, R_MAX};
    localparam logic [QW-1:0]   Q_NEG_LIM = {{FRAC{1'b0}}, R_MIN};
    localparam logic [CW-1:0]   ITER_LAST = CW'(QW - 1);

    div_state_t     state_reg;
    logic [CW-1:0]  cnt_reg;
    logic [QW-1:0]  quo_reg;
    logic [N-1:0]   rem_reg;
    logic [N-1:0]   div_reg;
    logic           sign_reg;
    logic           a_neg_reg;
    logic           dz_reg;

    logic [N-1:0]   r_reg;
    logic           z_reg;
    logic           c_reg;
    logic           v_reg;
    logic           neg_reg;
    logic           dz_out_reg;
    logic           busy_reg;
    logic           done_reg;

    logic [N-1:0]   a_mag;
    logic [N-1:0]   b_mag;
    logic [N-1:0]   step_rem;
    logic           step_q;
    logic [N-1:0]   fix_r;
    logic           fix_v;
    logic           fix_c;

    // N-bit unsigned magnitudes: the most negative operand maps to 2^(N-1) exactly.
    assign a_mag = A[N-1] ? -A : A;
    assign b_mag = B[N-1] ? -B : B;

    // quo_reg shifts dividend bits out of the top while quotient bits enter at the bottom.
    div_step #(.N(N)) u_step (
        .rem_in  (rem_reg),
        .bit_in  (quo_reg[QW-1]),
        .divisor (div_reg),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    always_comb begin
        fix_r = quo_reg[N-1:0];
        fix_v = 1'b0;
        fix_c = |rem_reg;
        if (dz_reg) begin
            fix_r = a_neg_reg ? R_MIN : R_MAX;
            fix_v = 1'b1;
            fix_c = 1'b0;
        end else if (!sign_reg && (quo_reg > Q_POS_LIM)) begin
            fix_r = R_MAX;
            fix_v = 1'b1;
            fix_c = 1'b0;
        end else if (sign_reg && (quo_reg > Q_NEG_LIM)) begin
            fix_r = R_MIN;
            fix_v = 1'b1;
            fix_c = 1'b0;
        end else if (sign_reg) begin
            fix_r = -quo_reg[N-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            quo_reg    <= '0;
            rem_reg    <= '0;
            div_reg    <= '0;
            sign_reg   <= 1'b0;
            a_neg_reg  <= 1'b0;
            dz_reg     <= 1'b0;
            r_reg      <= '0;
            z_reg      <= 1'b1;
            c_reg      <= 1'b0;
            v_reg      <= 1'b0;
            neg_reg    <= 1'b0;
            dz_out_reg <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg <= CALC;
                        busy_reg  <= 1'b1;
                        cnt_reg   <= ITER_LAST;
                        quo_reg   <= {a_mag, {FRAC{1'b0}}};
                        rem_reg   <= '0;
                        div_reg   <= b_mag;
                        sign_reg  <= A[N-1] ^ B[N-1];
                        a_neg_reg <= A[N-1];
                        dz_reg    <= (B == '0);
                    end
                end
                CALC: begin
                    rem_reg <= step_rem;
                    quo_reg <= {quo_reg[QW-2:0], step_q};
                    if (cnt_reg == '0) begin
                        state_reg <= FIX;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                FIX: begin
                    r_reg      <= fix_r;
                    z_reg      <= (fix_r == '0);
                    c_reg      <= fix_c;
                    v_reg      <= fix_v;
                    neg_reg    <= fix_r[N-1];
                    dz_out_reg <= dz_reg;
                    busy_reg   <= 1'b0;
                    done_reg   <= 1'b1;
                    state_reg  <= DONE;
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign R    = r_reg;
    assign Z    = z_reg;
    assign C    = c_reg;
    assign V    = v_reg;
    assign Neg  = neg_reg;
    assign DZ   = dz_out_reg;

endmodule

// File: tb/tb_fixed_point_divider.sv
// Scoreboard bench for fixed_point_divider: driver pushes model results, monitor pops on done.
module tb_fixed_point_divider;
    import reverb_pkg::*;

    localparam int LATENCY = 34;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [23:0] A;
    logic [23:0] B;
    logic        busy;
    logic        done;
    logic [23:0] R;
    logic        Z;
    logic        C;
    logic        V;
    logic        Neg;
    logic        DZ;

    typedef struct {
        logic [23:0] a;
        logic [23:0] b;
        logic [23:0] r;
        logic        z;
        logic        c;
        logic        v;
        logic        neg;
        logic        dz;
        int          start_edge;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          txn = 0;
    logic [23:0] last_r = '0;

    fixed_point_divider dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .R     (R),
        .Z     (Z),
        .C     (C),
        .V     (V),
        .Neg   (Neg),
        .DZ    (DZ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Plain-arithmetic reference: scale, divide with truncation toward zero, saturate.
    function automatic exp_t model(input logic [23:0] a, input logic [23:0] b);
        exp_t   e;
        longint sa;
        longint sb;
        longint q;
        longint rm;
        sa    = longint'($signed(a));
        sb    = longint'($signed(b));
        e.a   = a;
        e.b   = b;
        e.dz  = (sb == 0);
        e.c   = 1'b0;
        e.v   = 1'b0;
        e.start_edge = 0;
        if (sb == 0) begin
            e.r = (sa < 0) ? Q_MIN : Q_MAX;
            e.v = 1'b1;
        end else begin
            q  = (sa * 256) / sb;
            rm = (sa * 256) % sb;
            if (q > 64'sd8388607) begin
                e.r = Q_MAX;
                e.v = 1'b1;
            end else if (q < -64'sd8388608) begin
                e.r = Q_MIN;
                e.v = 1'b1;
            end else begin
                e.r = q[23:0];
                e.c = (rm != 0);
            end
        end
        e.z   = (e.r == 24'h0);
        e.neg = e.r[23];
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && done) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    txn++;
                    $display("txn %0d: A=%h B=%h -> R=%h Z=%b C=%b V=%b Neg=%b DZ=%b (exp R=%h)",
                             txn, e.a, e.b, R, Z, C, V, Neg, DZ, e.r);
                    chk("result_R", {8'h0, R}, {8'h0, e.r});
                    chk("flags_ZCVND", {27'h0, Z, C, V, Neg, DZ},
                        {27'h0, e.z, e.c, e.v, e.neg, e.dz});
                    chk("latency", 32'(cyc + 1 - e.start_edge), 32'(LATENCY));
                    last_r = e.r;
                end
            end
        end
    end

    task automatic run_op(input logic [23:0] a, input logic [23:0] b, input bit extra_pulse);
        exp_t e;
        int   n;
        @(negedge clk);
        A     = a;
        B     = b;
        start = 1'b1;
        e     = model(a, b);
        e.start_edge = cyc + 1;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        A     = 24'($urandom);
        B     = 24'($urandom);
        repeat (4) @(negedge clk);
        chk("busy_during_calc", {31'h0, busy}, 32'd1);
        chk("R_held", {8'h0, R}, {8'h0, last_r});
        if (extra_pulse) begin
            repeat (4) @(negedge clk);
            start = 1'b1;
            A     = 24'h000100;
            B     = 24'h000200;
            @(negedge clk);
            start = 1'b0;
        end
        n = 0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!done) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic mid_reset(input logic [23:0] a, input logic [23:0] b);
        exp_t e;
        @(negedge clk);
        A     = a;
        B     = b;
        start = 1'b1;
        e     = model(a, b);
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        repeat (13) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_busy", {31'h0, busy}, 32'd0);
        chk("rst_done", {31'h0, done}, 32'd0);
        chk("rst_R", {8'h0, R}, 32'h0);
        chk("rst_Z", {31'h0, Z}, 32'd1);
        sb_q.delete();
        last_r = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("idle_after_reset", {30'h0, busy, done}, 32'd0);
    endtask

    initial begin
        logic [23:0] ra;
        logic [23:0] rb;
        int          mode;
        rst_n = 1'b0;
        start = 1'b0;
        A     = '0;
        B     = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy_done", {30'h0, busy, done}, 32'd0);
        chk("reset_R", {8'h0, R}, 32'h0);
        chk("reset_flags_ZCVND", {27'h0, Z, C, V, Neg, DZ}, 32'b10000);
        rst_n = 1'b1;

        run_op(24'h000180, 24'h000060, 1'b0);
        run_op(24'h000100, 24'hFFFFC0, 1'b0);
        run_op(24'h000100, 24'h000300, 1'b0);
        run_op(24'h000000, 24'h000300, 1'b0);
        run_op(24'hFFFF00, 24'h000000, 1'b0);
        run_op(24'h000100, 24'h000000, 1'b0);
        run_op(24'h7FFFFF, 24'h000001, 1'b0);
        run_op(24'h800000, 24'h000100, 1'b0);
        run_op(24'h800000, 24'hFFFF00, 1'b0);
        run_op(24'h001234, 24'h000456, 1'b1);
        mid_reset(24'h000300, 24'h000100);
        run_op(24'hFFF000, 24'h000700, 1'b0);

        for (int i = 0; i < 40; i++) begin
            mode = int'($urandom_range(0, 3));
            ra   = 24'($urandom);
            rb   = 24'($urandom);
            case (mode)
                1: rb = 24'($urandom_range(1, 24'h000FFF));
                2: rb = 24'h0;
                3: ra = 24'($urandom_range(0, 24'h003FFF));
                default: ;
            endcase
            if (mode != 2 && $urandom_range(0, 1) == 1) rb = -rb;
            run_op(ra, rb, 1'b0);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
